mc_sequencer: RTL

- Multi-cycle control FSM for the MIPS-subset datapath (PC, IR, register file, ALU, a single shared instruction/data memory port).
- Replaces single-cycle control: sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Waits on the memory ready handshake and drives every datapath select and enable.
- Halts on an illegal opcode or a memory timeout, and counts retired instructions.

---
 rtl/mc_sequencer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc_sequencer
// Purpose  : Multi-cycle control FSM for a MIPS-subset datapath. Walks each
//            instruction through FETCH, DECODE, EXEC, MEM and WB. Waits on the
//            shared memory port's ready handshake. Drives every datapath
//            select and enable, and counts retired instructions. Halts on an
//            illegal instruction or a memory timeout.
// Ports    : i_clk, i_rst_n (async, active low)
//            i_opcode/i_funct   : IR fields, valid from DECODE onward
//            i_alu_zero         : ALU zero flag (BNE resolution)
//            i_mem_ready        : memory completes current access this cycle
//            o_pc_wr_en/o_pc_src, o_ir_wr_en, o_mdr_wr_en, o_iord,
//            o_mem_rd_en/o_mem_wr_en, o_wr_reg_sel, o_reg_wr_en, o_wb_src,
//            o_ext_sel, o_alu_src_b, o_alu_cmd : datapath controls
//            o_state, o_halted, o_halt_cause, o_instr_count : status
// Revision : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_alu_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_wr_en,
  output logic [1:0]       o_pc_src,
  output logic             o_ir_wr_en,
  output logic             o_mdr_wr_en,
  output logic             o_iord,
  output logic             o_mem_rd_en,
  output logic             o_mem_wr_en,
  output logic [1:0]       o_wr_reg_sel,
  output logic             o_reg_wr_en,
  output logic [1:0]       o_wb_src,
  output logic             o_ext_sel,
  output logic             o_alu_src_b,
  output logic [2:0]       o_alu_cmd,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic [1:0]       o_halt_cause,
  output logic [CNT_W-1:0] o_instr_count
);

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_J     = 6'h02;
  localparam logic [5:0] C_OP_JAL   = 6'h03;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_XORI  = 6'h0E;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;
  localparam logic [5:0] C_FN_JR    = 6'h08;
  localparam logic [5:0] C_FN_ADD   = 6'h20;
  localparam logic [5:0] C_FN_SUB   = 6'h22;
  localparam logic [5:0] C_FN_SLT   = 6'h2A;

  localparam int              C_WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int              C_LAST_INT  = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(C_LAST_INT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [C_WAIT_W-1:0] r_wait;
  logic [1:0]          r_halt_cause;
  logic [CNT_W-1:0]    r_count;

  // Instruction classification
  logic w_rtype, w_r_alu, w_jr, w_legal_exec, w_is_lw, w_is_sw;
  assign w_rtype      = (i_opcode == C_OP_RTYPE);
  assign w_r_alu      = w_rtype && ((i_funct == C_FN_ADD) || (i_funct == C_FN_SUB) ||
                                    (i_funct == C_FN_SLT));
  assign w_jr         = w_rtype && (i_funct == C_FN_JR);
  assign w_is_lw      = (i_opcode == C_OP_LW);
  assign w_is_sw      = (i_opcode == C_OP_SW);
  assign w_legal_exec = w_r_alu || w_is_lw || w_is_sw || (i_opcode == C_OP_ADDI) ||
                        (i_opcode == C_OP_XORI) || (i_opcode == C_OP_BNE);

  // The counter holds the number of wait cycles already spent. The current
  // cycle is the one that reaches the limit when the counter equals limit-1.
  // A ready in that same cycle still takes precedence.
  logic w_wait_hit;
  assign w_wait_hit = (MEM_TIMEOUT != 0) && (r_wait == C_WAIT_LAST) && !i_mem_ready;

  // ALU controls depend only on the instruction. Applying them in EXEC, MEM
  // and WB keeps them stable for the whole execute/memory/writeback span.
  logic       w_alu_src_b, w_ext_sel;
  logic [2:0] w_alu_cmd;
  always_comb begin
    w_alu_src_b = 1'b0;
    w_ext_sel   = 1'b0;
    w_alu_cmd   = 3'd0;
    if (w_rtype) begin
      if (i_funct == C_FN_SUB)      w_alu_cmd = 3'd1;
      else if (i_funct == C_FN_SLT) w_alu_cmd = 3'd3;
    end else if (i_opcode == C_OP_XORI) begin
      w_alu_src_b = 1'b1;
      w_alu_cmd   = 3'd2;
    end else if (i_opcode == C_OP_BNE) begin
      w_alu_cmd   = 3'd1;
    end else if ((i_opcode == C_OP_ADDI) || w_is_lw || w_is_sw) begin
      w_alu_src_b = 1'b1;
      w_ext_sel   = 1'b1;
    end
  end

  logic       w_pc_wr, w_ir_wr, w_mdr_wr, w_iord, w_rd, w_wr, w_reg_wr, w_retire;
  logic       w_alu_on;
  logic [1:0] w_pc_src, w_wr_reg_sel, w_wb_src, w_cause;

  always_comb begin
    w_next       = r_state;
    w_pc_wr      = 1'b0;
    w_pc_src     = 2'd0;
    w_ir_wr      = 1'b0;
    w_mdr_wr     = 1'b0;
    w_iord       = 1'b0;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_wr_reg_sel = 2'd0;
    w_reg_wr     = 1'b0;
    w_wb_src     = 2'd0;
    w_retire     = 1'b0;
    w_alu_on     = 1'b0;
    w_cause      = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_rd = 1'b1;
        if (i_mem_ready) begin
          w_ir_wr = 1'b1;
          w_next  = S_DECODE;
        end else if (w_wait_hit) begin
          w_next  = S_HALT;
          w_cause = 2'd2;
        end
      end
      S_DECODE: begin
        if (i_opcode == C_OP_J) begin
          w_pc_wr  = 1'b1;
          w_pc_src = 2'd2;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (i_opcode == C_OP_JAL) begin
          w_reg_wr     = 1'b1;
          w_wr_reg_sel = 2'd2;
          w_wb_src     = 2'd2;
          w_pc_wr      = 1'b1;
          w_pc_src     = 2'd2;
          w_retire     = 1'b1;
          w_next       = S_FETCH;
        end else if (w_jr) begin
          w_pc_wr  = 1'b1;
          w_pc_src = 2'd1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_legal_exec) begin
          w_next = S_EXEC;
        end else begin
          w_next  = S_HALT;
          w_cause = 2'd1;
        end
      end
      S_EXEC: begin
        w_alu_on = 1'b1;
        if (i_opcode == C_OP_BNE) begin
          w_pc_wr  = 1'b1;
          w_pc_src = i_alu_zero ? 2'd0 : 2'd3;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_alu_on = 1'b1;
        w_iord   = 1'b1;
        w_rd     = w_is_lw;
        w_wr     = !w_is_lw;
        if (i_mem_ready) begin
          if (w_is_lw) begin
            w_mdr_wr = 1'b1;
            w_next   = S_WB;
          end else begin
            w_pc_wr  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (w_wait_hit) begin
          w_next  = S_HALT;
          w_cause = 2'd2;
        end
      end
      S_WB: begin
        w_alu_on     = 1'b1;
        w_reg_wr     = 1'b1;
        w_pc_wr      = 1'b1;
        w_wr_reg_sel = w_rtype ? 2'd0 : 2'd1;
        w_wb_src     = w_is_lw ? 2'd1 : 2'd0;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_FETCH;
      r_wait       <= '0;
      r_halt_cause <= 2'd0;
      r_count      <= '0;
    end else begin
      r_state <= w_next;
      // Any state change clears the wait counter, covering entry to FETCH/MEM.
      if (w_next != r_state)
        r_wait <= '0;
      else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready)
        r_wait <= r_wait + 1'b1;
      if ((r_state != S_HALT) && (w_next == S_HALT))
        r_halt_cause <= w_cause;
      if (w_retire)
        r_count <= r_count + CNT_W'(1);
    end
  end

  // Enables are masked by reset so that nothing is written while reset is
  // asserted, even though the reset state (FETCH) would request a read.
  assign o_pc_wr_en    = w_pc_wr  & i_rst_n;
  assign o_ir_wr_en    = w_ir_wr  & i_rst_n;
  assign o_mdr_wr_en   = w_mdr_wr & i_rst_n;
  assign o_mem_rd_en   = w_rd     & i_rst_n;
  assign o_mem_wr_en   = w_wr     & i_rst_n;
  assign o_reg_wr_en   = w_reg_wr & i_rst_n;
  assign o_pc_src      = w_pc_src;
  assign o_iord        = w_iord;
  assign o_wr_reg_sel  = w_wr_reg_sel;
  assign o_wb_src      = w_wb_src;
  assign o_alu_src_b   = w_alu_on & w_alu_src_b;
  assign o_ext_sel     = w_alu_on & w_ext_sel;
  assign o_alu_cmd     = w_alu_on ? w_alu_cmd : 3'd0;
  assign o_state       = r_state;
  assign o_halted      = (r_state == S_HALT);
  assign o_halt_cause  = r_halt_cause;
  assign o_instr_count = r_count;

endmodule
`default_nettype wire
